// File: rtl/param_buffer_if.sv
// ---------------------------------------------------------------------------
// param_buffer_if
// Bundle of every signal between the parameter buffer and the blocks around
// it: the beat stream from the DDR parameter reader, the kernel-bank status
// and release handshake, and the two random-access read ports.
//
//   master : the producer / conv-engine side (drives beats, ker_done, read addresses)
//   slave  : the parameter buffer itself
//
// Signals
//   param_valid      1    beat on param_data is valid
//   param_bias_valid 1    qualifies the current valid beat as bias (else kernel)
//   param_data       DW   parameter beat
//   buf_full         1    both kernel banks full
//   buf_ovf          1    sticky: a kernel beat arrived while buf_full
//   ker_ready        1    read bank holds a complete kernel set
//   ker_done         1    pulse: consumer releases the read bank
//   ker_rd_addr      5    kernel beat index in the read bank
//   ker_rd_data      DW   registered kernel beat
//   bias_rd_addr     9    bias index 0..511
//   bias_rd_data     FW   registered bias float
// ---------------------------------------------------------------------------
interface param_buffer_if #(
  parameter int DATA_WIDTH  = 512,
  parameter int FLOAT_WIDTH = 32
);
  logic                   param_valid;
  logic                   param_bias_valid;
  logic [DATA_WIDTH-1:0]  param_data;
  logic                   buf_full;
  logic                   buf_ovf;
  logic                   ker_ready;
  logic                   ker_done;
  logic [4:0]             ker_rd_addr;
  logic [DATA_WIDTH-1:0]  ker_rd_data;
  logic [8:0]             bias_rd_addr;
  logic [FLOAT_WIDTH-1:0] bias_rd_data;

  modport master (
    output param_valid, param_bias_valid, param_data,
    output ker_done, ker_rd_addr, bias_rd_addr,
    input  buf_full, buf_ovf, ker_ready, ker_rd_data, bias_rd_data
  );

  modport slave (
    input  param_valid, param_bias_valid, param_data,
    input  ker_done, ker_rd_addr, bias_rd_addr,
    output buf_full, buf_ovf, ker_ready, ker_rd_data, bias_rd_data
  );
endinterface

// File: rtl/param_buffer.sv
// ---------------------------------------------------------------------------
// param_buffer
// Sink of the DDR parameter reader. Bias beats go to a linear bias store;
// kernel beats go to a two-bank ping-pong kernel store so the conv engine can
// read one complete kernel set while the next one is loading. Both stores are
// read back through registered random-access ports (1-cycle latency).
//
// Ports
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   pb     param_buffer_if.slave  (beat input, bank status, read ports)
// ---------------------------------------------------------------------------
module param_buffer #(
  parameter int DATA_WIDTH     = 512,
  parameter int FLOAT_WIDTH    = 32,
  parameter int KER_BEATS      = 18,
  parameter int BIAS_BEATS_MAX = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  param_buffer_if.slave  pb
);

  localparam int         LANES     = DATA_WIDTH / FLOAT_WIDTH;
  localparam logic [4:0] KER_LAST  = 5'(KER_BEATS - 1);
  localparam logic [4:0] BIAS_LAST = 5'(BIAS_BEATS_MAX - 1);

  // Storage: deliberately not reset, contents are don't-care after reset.
  logic [DATA_WIDTH-1:0]               ker_mem_q  [2][KER_BEATS];
  logic [LANES-1:0][FLOAT_WIDTH-1:0]   bias_mem_q [BIAS_BEATS_MAX];

  logic [1:0]             full_q, full_d;
  logic                   wr_bank_q, wr_bank_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [4:0]             ker_wr_cnt_q, ker_wr_cnt_d;
  logic [4:0]             bias_wr_cnt_q, bias_wr_cnt_d;
  logic                   last_ker_q, last_ker_d;
  logic                   ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0]  ker_rd_data_q;
  logic [FLOAT_WIDTH-1:0] bias_rd_data_q;

  logic       bias_beat, ker_beat, ker_accept, ker_commit, done_eff;
  logic       buf_full_w, ker_ready_w;
  logic [4:0] bias_wr_idx;

  always_comb begin
    bias_beat   = pb.param_valid & pb.param_bias_valid;
    ker_beat    = pb.param_valid & ~pb.param_bias_valid;
    buf_full_w  = &full_q;
    ker_ready_w = full_q[rd_bank_q];
    ker_accept  = ker_beat & ~buf_full_w;
    ker_commit  = ker_accept & (ker_wr_cnt_q == KER_LAST);
    done_eff    = pb.ker_done & ker_ready_w;
    // A bias beat right after any kernel beat starts a new layer at entry 0.
    bias_wr_idx = last_ker_q ? 5'd0 : bias_wr_cnt_q;

    full_d        = full_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    ker_wr_cnt_d  = ker_wr_cnt_q;
    bias_wr_cnt_d = bias_wr_cnt_q;
    last_ker_d    = last_ker_q;
    ovf_d         = ovf_q | (ker_beat & buf_full_w);

    if (bias_beat) begin
      bias_wr_cnt_d = (bias_wr_idx == BIAS_LAST) ? 5'd0 : bias_wr_idx + 5'd1;
      last_ker_d    = 1'b0;
    end
    if (ker_beat) begin
      last_ker_d = 1'b1;
    end
    if (ker_accept) begin
      ker_wr_cnt_d = ker_commit ? 5'd0 : ker_wr_cnt_q + 5'd1;
    end
    if (ker_commit) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    // Commit only targets an empty bank and release only a full one, so the
    // two updates never hit the same bank and can both apply.
    if (done_eff) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q         <= '0;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      ker_wr_cnt_q   <= '0;
      bias_wr_cnt_q  <= '0;
      last_ker_q     <= 1'b0;
      ovf_q          <= 1'b0;
      ker_rd_data_q  <= '0;
      bias_rd_data_q <= '0;
    end else begin
      full_q         <= full_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      ker_wr_cnt_q   <= ker_wr_cnt_d;
      bias_wr_cnt_q  <= bias_wr_cnt_d;
      last_ker_q     <= last_ker_d;
      ovf_q          <= ovf_d;
      ker_rd_data_q  <= (ker_ready_w && (pb.ker_rd_addr <= KER_LAST))
                        ? ker_mem_q[rd_bank_q][pb.ker_rd_addr] : '0;
      // Reads see the store before this cycle's write (read-old-data).
      bias_rd_data_q <= bias_mem_q[pb.bias_rd_addr[8:4]][pb.bias_rd_addr[3:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (ker_accept) begin
      ker_mem_q[wr_bank_q][ker_wr_cnt_q] <= pb.param_data;
    end
    if (bias_beat) begin
      bias_mem_q[bias_wr_idx] <= pb.param_data;
    end
  end

  assign pb.buf_full     = buf_full_w;
  assign pb.buf_ovf      = ovf_q;
  assign pb.ker_ready    = ker_ready_w;
  assign pb.ker_rd_data  = ker_rd_data_q;
  assign pb.bias_rd_data = bias_rd_data_q;

endmodule
